// File: rtl/rs_pkg.sv
// Shared types for the logical-FU reservation station.
// Holds the entry record layout and the operand/data geometry constants.
package rs_pkg;

  localparam int unsigned NUM_SRC  = 3;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned RS_PRN_W = 7;
  localparam int unsigned RS_ID_W  = 5;

  // Operand slot k lives at index k, so src_prn/src_val/dst_prn map
  // bit-for-bit onto the concatenated dispatch and issue buses.
  typedef struct packed {
    logic                              valid;
    logic [31:0]                       inst;
    logic [RS_ID_W-1:0]                inst_id;
    logic [NUM_SRC-1:0][RS_PRN_W-1:0]  src_prn;
    logic [NUM_SRC-1:0]                src_rdy;
    logic [NUM_SRC-1:0][DATA_W-1:0]    src_val;
    logic [NUM_SRC-1:0][RS_PRN_W-1:0]  dst_prn;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_picker.sv
// Age-matrix oldest-first picker.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clear      synchronous clear of all age state
//   alloc      one-hot: entry being written this cycle (becomes youngest)
//   free       one-hot: entry being released this cycle
//   req        mask of entries eligible for selection
//   grant      one-hot oldest requesting entry (combinational from state)
module rs_age_picker #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  // older_q[i][j] set: entry i was allocated before entry j.
  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];
  logic [DEPTH-1:0] blocked;

  always_comb begin
    older_d = older_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (free[i]) older_d[i] = '0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (alloc[i]) begin
        older_d[i] = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (j != i) older_d[j][i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  always_comb begin
    blocked = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (j != i && req[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
    end
    grant = req & ~blocked;
  end

endmodule

// File: rtl/rs_logical.sv
// Reservation station for the logical FU.
// Buffers dispatched instructions, tracks readiness of op0 (Xn), op1 (Xm)
// and op2 (NZCV flags in [3:0], upper bits passed through), captures operand
// values from the CDB and issues the oldest fully-ready entry when fu_ready.
// Ports:
//   clk, rst, flush          clock, sync active-high reset, sync squash
//   disp_*                   dispatch request/payload, disp_ready = free slot
//   cdb_valid/prn/data       CDB_N broadcast ports (lowest port wins)
//   fu_ready                 FU accepts an instruction this cycle
//   issue_*                  registered issue fields, issue_valid one-cycle pulse
// Optional: RS_LOGICAL_PERF_EN adds perf_issued / perf_full saturating counters.
module rs_logical
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PRN_W = RS_PRN_W,
  parameter int unsigned ID_W  = RS_ID_W,
  parameter int unsigned CDB_N = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [31:0]               disp_inst,
  input  logic [ID_W-1:0]           disp_inst_id,
  input  logic [NUM_SRC*PRN_W-1:0]  disp_src_prn,
  input  logic [NUM_SRC-1:0]        disp_src_rdy,
  input  logic [NUM_SRC*DATA_W-1:0] disp_src_val,
  input  logic [NUM_SRC*PRN_W-1:0]  disp_dst_prn,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*PRN_W-1:0]    cdb_prn,
  input  logic [CDB_N*DATA_W-1:0]   cdb_data,
  input  logic                      fu_ready,
  output logic                      issue_valid,
  output logic [31:0]               issue_inst,
  output logic [ID_W-1:0]           issue_inst_id,
  output logic [NUM_SRC*DATA_W-1:0] issue_op,
  output logic [NUM_SRC*PRN_W-1:0]  issue_dst_prn
`ifdef RS_LOGICAL_PERF_EN
  ,
  output logic [31:0]               perf_issued,
  output logic [31:0]               perf_full
`endif
);

  if (PRN_W != RS_PRN_W || ID_W != RS_ID_W) begin : g_width_check
    $error("rs_logical: PRN_W/ID_W must match rs_pkg entry layout");
  end

  rs_entry_t ent_q [DEPTH];
  rs_entry_t ent_d [DEPTH];
  rs_entry_t disp_ent;

  logic [DEPTH-1:0] valid_vec, req_vec, grant, alloc_oh, free_oh;
  logic             alloc_found;
  logic             clear, do_disp, do_issue;

  logic [31:0]               iss_inst;
  logic [ID_W-1:0]           iss_id;
  logic [NUM_SRC*DATA_W-1:0] iss_op;
  logic [NUM_SRC*PRN_W-1:0]  iss_dst;

  // Capture CDB data into not-yet-ready operands; lowest matching port wins.
  function automatic rs_entry_t wake(input rs_entry_t e,
                                     input logic [CDB_N-1:0] v,
                                     input logic [CDB_N*PRN_W-1:0] prn,
                                     input logic [CDB_N*DATA_W-1:0] data);
    rs_entry_t r;
    logic      hit;
    r = e;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      hit = 1'b0;
      for (int unsigned p = 0; p < CDB_N; p++) begin
        if (!hit && !r.src_rdy[s] && v[p] && prn[p*PRN_W +: PRN_W] == r.src_prn[s]) begin
          r.src_val[s] = data[p*DATA_W +: DATA_W];
          hit          = 1'b1;
        end
      end
      if (hit) r.src_rdy[s] = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent_q[i].valid;
      req_vec[i]   = ent_q[i].valid && (&ent_q[i].src_rdy);
    end
  end

  // Occupancy is taken from registered state only, so a slot freed by this
  // cycle's issue is not reusable until the next cycle.
  assign disp_ready = ~&valid_vec;
  assign clear      = rst || flush;
  assign do_disp    = disp_valid && disp_ready && !clear;
  assign do_issue   = fu_ready && (|req_vec) && !clear;
  assign free_oh    = do_issue ? grant : '0;

  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !alloc_found) begin
        alloc_oh[i] = do_disp;
        alloc_found = 1'b1;
      end
    end
  end

  rs_age_picker #(.DEPTH(DEPTH)) u_age (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .alloc (alloc_oh),
    .free  (free_oh),
    .req   (req_vec),
    .grant (grant)
  );

  always_comb begin
    disp_ent         = '0;
    disp_ent.valid   = 1'b1;
    disp_ent.inst    = disp_inst;
    disp_ent.inst_id = disp_inst_id;
    disp_ent.src_prn = disp_src_prn;
    disp_ent.src_rdy = disp_src_rdy;
    disp_ent.src_val = disp_src_val;
    disp_ent.dst_prn = disp_dst_prn;
    disp_ent         = wake(disp_ent, cdb_valid, cdb_prn, cdb_data);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = wake(ent_q[i], cdb_valid, cdb_prn, cdb_data);
      if (free_oh[i])  ent_d[i].valid = 1'b0;
      if (alloc_oh[i]) ent_d[i] = disp_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      ent_q <= ent_d;
    end
  end

  always_comb begin
    iss_inst = '0;
    iss_id   = '0;
    iss_op   = '0;
    iss_dst  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        iss_inst = iss_inst | ent_q[i].inst;
        iss_id   = iss_id   | ent_q[i].inst_id;
        iss_op   = iss_op   | ent_q[i].src_val;
        iss_dst  = iss_dst  | ent_q[i].dst_prn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid   <= 1'b0;
      issue_inst    <= '0;
      issue_inst_id <= '0;
      issue_op      <= '0;
      issue_dst_prn <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else begin
      issue_valid <= do_issue;
      if (do_issue) begin
        issue_inst    <= iss_inst;
        issue_inst_id <= iss_id;
        issue_op      <= iss_op;
        issue_dst_prn <= iss_dst;
      end
    end
  end

`ifdef RS_LOGICAL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_full   <= '0;
    end else begin
      if (do_issue && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if (disp_valid && !disp_ready && perf_full != '1) perf_full <= perf_full + 32'd1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_rs_logical.sv
module tb_rs_logical;
  localparam int PRN_W = 7;
  localparam int ID_W  = 5;
  localparam int CDB_N = 2;

  logic                 clk = 1'b0;
  logic                 rst, flush, disp_valid, disp_ready, fu_ready;
  logic [31:0]          disp_inst;
  logic [ID_W-1:0]      disp_inst_id;
  logic [3*PRN_W-1:0]   disp_src_prn, disp_dst_prn;
  logic [2:0]           disp_src_rdy;
  logic [191:0]         disp_src_val;
  logic [CDB_N-1:0]     cdb_valid;
  logic [CDB_N*PRN_W-1:0] cdb_prn;
  logic [CDB_N*64-1:0]  cdb_data;
  logic                 issue_valid;
  logic [31:0]          issue_inst;
  logic [ID_W-1:0]      issue_inst_id;
  logic [191:0]         issue_op;
  logic [3*PRN_W-1:0]   issue_dst_prn;
`ifdef RS_LOGICAL_PERF_EN
  logic [31:0]          perf_issued, perf_full;
`endif

  rs_logical #(.DEPTH(4), .PRN_W(PRN_W), .ID_W(ID_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst(disp_inst),
    .disp_inst_id(disp_inst_id), .disp_src_prn(disp_src_prn), .disp_src_rdy(disp_src_rdy),
    .disp_src_val(disp_src_val), .disp_dst_prn(disp_dst_prn),
    .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_data(cdb_data),
    .fu_ready(fu_ready), .issue_valid(issue_valid), .issue_inst(issue_inst),
    .issue_inst_id(issue_inst_id), .issue_op(issue_op), .issue_dst_prn(issue_dst_prn)
`ifdef RS_LOGICAL_PERF_EN
    , .perf_issued(perf_issued), .perf_full(perf_full)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0]        inst;
    logic [ID_W-1:0]    id;
    logic [191:0]       op;
    logic [3*PRN_W-1:0] dst;
    int                 cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0]        inst;
    logic [ID_W-1:0]    id;
    logic [191:0]       val;
    logic [3*PRN_W-1:0] dst;
    logic [191:0]       exp_op;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard consumer: every issue pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && issue_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_issue: got id %0d at cycle %0d, expected no issue", issue_inst_id, cyc);
      end else begin
        e = sb.pop_front();
        chk("issue_id",   192'(issue_inst_id), 192'(e.id));
        chk("issue_inst", 192'(issue_inst),    192'(e.inst));
        chk("issue_op",   issue_op,            e.op);
        chk("issue_dst",  192'(issue_dst_prn), 192'(e.dst));
        chk("issue_cycle", 192'(cyc),          192'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    disp_valid = 1'b0;
    cdb_valid  = '0;
    flush      = 1'b0;
  endtask

  task automatic drive_disp(input logic [31:0] inst, input logic [ID_W-1:0] id,
                            input logic [3*PRN_W-1:0] prn, input logic [2:0] rdy,
                            input logic [191:0] val, input logic [3*PRN_W-1:0] dst);
    disp_valid   = 1'b1;
    disp_inst    = inst;
    disp_inst_id = id;
    disp_src_prn = prn;
    disp_src_rdy = rdy;
    disp_src_val = val;
    disp_dst_prn = dst;
  endtask

  task automatic push(input logic [31:0] inst, input logic [ID_W-1:0] id,
                      input logic [191:0] op, input logic [3*PRN_W-1:0] dst, input int c);
    exp_t e;
    e.inst = inst; e.id = id; e.op = op; e.dst = dst; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_cdb(input int port, input logic [PRN_W-1:0] prn, input logic [63:0] data);
    cdb_valid[port]              = 1'b1;
    cdb_prn[port*PRN_W +: PRN_W] = prn;
    cdb_data[port*64 +: 64]      = data;
  endtask

  int n;

  initial begin
    vt[0] = '{32'hAA0203E0, 5'd1, {64'h0, 64'h2, 64'h1}, {7'd3, 7'd2, 7'd1}, {64'h0, 64'h2, 64'h1}};
    vt[1] = '{32'h4A000000, 5'd2, {64'hFFFF_FFFF_FFFF_FFF5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF},
              {7'd127, 7'd0, 7'd64}, {64'hFFFF_FFFF_FFFF_FFF5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}};
    vt[2] = '{32'hCA010020, 5'd3, {64'hA, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D},
              {7'd10, 7'd11, 7'd12}, {64'hA, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D}};
    vt[3] = '{32'h0, 5'd4, 192'h0, 21'h0, 192'h0};
    vt[4] = '{32'hFFFFFFFF, 5'd31, {64'h8000_0000_0000_0003, 64'h1, 64'h8000_0000_0000_0000},
              {7'd5, 7'd6, 7'd7}, {64'h8000_0000_0000_0003, 64'h1, 64'h8000_0000_0000_0000}};

    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; fu_ready = 1'b1;
    disp_inst = '0; disp_inst_id = '0; disp_src_prn = '0; disp_src_rdy = '0;
    disp_src_val = '0; disp_dst_prn = '0; cdb_valid = '0; cdb_prn = '0; cdb_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_issue_valid", 192'(issue_valid), 192'(0));
    chk("rst_disp_ready",  192'(disp_ready),  192'(1));
    chk("rst_issue_inst",  192'(issue_inst),  192'(0));
    chk("rst_issue_op",    issue_op,          192'(0));

    // All-ready dispatches back to back: each issues exactly two cycles later.
    for (int i = 0; i < 5; i++) begin
      drive_disp(vt[i].inst, vt[i].id, 21'h0, 3'b111, vt[i].val, vt[i].dst);
      push(vt[i].inst, vt[i].id, vt[i].exp_op, vt[i].dst, cyc + 2);
      step();
    end
    repeat (3) step();
    chk("freed_disp_ready", 192'(disp_ready), 192'(1));

    // op1 woken by CDB port 1 two cycles after dispatch.
    n = cyc;
    drive_disp(32'h2A0C0000, 5'd6, {7'd0, 7'd12, 7'd0}, 3'b101,
               {64'h3, 64'h1111, 64'h5}, {7'd9, 7'd8, 7'd7});
    push(32'h2A0C0000, 5'd6, {64'h3, 64'hDEAD, 64'h5}, {7'd9, 7'd8, 7'd7}, n + 4);
    step();
    step();
    cdb_prn[6:0] = 7'd12; cdb_data[63:0] = 64'hBAD;  // port 0 not valid
    set_cdb(1, 7'd12, 64'hDEAD);
    step();
    repeat (3) step();

    // Fill all four entries waiting on op0, wake in reverse order, issue oldest first.
    n = cyc;
    for (int k = 0; k < 4; k++) begin
      drive_disp(32'h0A000000 + k, 5'(11 + k), {7'd0, 7'd0, 7'(20 + k)}, 3'b110,
                 {64'(k), 64'(k), 64'hFFFF}, 21'(k));
      push(32'h0A000000 + k, 5'(11 + k), {64'(k), 64'(k), 64'(256 + k)}, 21'(k), n + 8 + k);
      step();
    end
    fu_ready = 1'b0;
    chk("full_disp_ready", 192'(disp_ready), 192'(0));
    drive_disp(32'h1, 5'd19, 21'h0, 3'b111, 192'h77, 21'h0);  // must be refused
    set_cdb(0, 7'd23, 64'h103);
    set_cdb(1, 7'd22, 64'h102);
    step();
    set_cdb(0, 7'd21, 64'h101);
    set_cdb(1, 7'd20, 64'h100);
    step();
    step();
    chk("full_no_reuse", 192'(disp_ready), 192'(0));
    fu_ready = 1'b1;
    step();
    chk("freed_after_issue", 192'(disp_ready), 192'(1));
    repeat (5) step();

    // Dispatch-cycle wakeup on op0.
    n = cyc;
    drive_disp(32'h12345678, 5'd15, {7'd0, 7'd0, 7'd5}, 3'b110, {64'h9, 64'h8, 64'h0}, {7'd1, 7'd1, 7'd1});
    set_cdb(0, 7'd5, 64'h7);
    push(32'h12345678, 5'd15, {64'h9, 64'h8, 64'h7}, {7'd1, 7'd1, 7'd1}, n + 2);
    step();
    repeat (2) step();

    // Both CDB ports match the same PRN: port 0 wins.
    n = cyc;
    drive_disp(32'h55AA55AA, 5'd16, {7'd30, 7'd0, 7'd0}, 3'b011, {64'h0, 64'h2, 64'h1}, {7'd2, 7'd2, 7'd2});
    push(32'h55AA55AA, 5'd16, {64'hA5A5, 64'h2, 64'h1}, {7'd2, 7'd2, 7'd2}, n + 3);
    step();
    set_cdb(0, 7'd30, 64'hA5A5);
    set_cdb(1, 7'd30, 64'h5A5A);
    step();
    repeat (3) step();

    // fu_ready held low three cycles with a ready entry.
    n = cyc;
    fu_ready = 1'b0;
    drive_disp(32'hCAFE0000, 5'd17, 21'h0, 3'b111, {64'h4, 64'h5, 64'h6}, {7'd4, 7'd4, 7'd4});
    push(32'hCAFE0000, 5'd17, {64'h4, 64'h5, 64'h6}, {7'd4, 7'd4, 7'd4}, n + 5);
    step();
    step();
    step();
    step();
    fu_ready = 1'b1;
    step();
    repeat (2) step();

    // Flush with three waiting entries plus a same-cycle dispatch: nothing ever issues.
    for (int k = 0; k < 3; k++) begin
      drive_disp(32'hF0, 5'(21 + k), {7'd0, 7'd0, 7'(40 + k)}, 3'b110, 192'h0, 21'h0);
      step();
    end
    flush = 1'b1;
    drive_disp(32'hF1, 5'd24, 21'h0, 3'b111, 192'h1, 21'h0);
    step();
    chk("flush_disp_ready", 192'(disp_ready), 192'(1));
    chk("flush_issue_valid", 192'(issue_valid), 192'(0));
    set_cdb(0, 7'd40, 64'h1);
    set_cdb(1, 7'd41, 64'h2);
    step();
    set_cdb(0, 7'd42, 64'h3);
    step();
    repeat (6) step();

    chk("sb_drain", 192'(sb.size()), 192'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
